// File: rtl/alu32_reg.sv
// Registered ALU execute stage: add/and/or/mul/sub/unsigned-slt with a zero flag.
// Optional build macro ALU_XOR_OP_EN makes opcode 111 compute A ^ B instead of 0.
module alu32_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] R,
  output logic             Z,
  output logic             out_valid
);

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] r_d, r_q;
  logic             z_d, z_q;
  logic             vld_d, vld_q;

  function automatic logic [WIDTH-1:0] alu_op(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] y;
    y = '0;
    case (op)
      3'b001:  y = a + b;
      3'b010:  y = a & b;
      3'b011:  y = a | b;
      // Product is evaluated at WIDTH bits, so the upper half is dropped.
      3'b100:  y = a * b;
      3'b101:  y = a - b;
      3'b110:  y = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_XOR_OP_EN
      3'b111:  y = a ^ b;
`else
      3'b111:  y = '0;
`endif
      default: y = '0;
    endcase
    return y;
  endfunction

  assign res = alu_op(sel, A, B);

  always_comb begin
    r_d   = r_q;
    z_d   = z_q;
    vld_d = 1'b0;
    if (in_valid) begin
      r_d   = res;
      z_d   = (res == '0);
      vld_d = 1'b1;
    end
  end

  // Execute stage output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      z_q   <= 1'b1;
      vld_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      z_q   <= z_d;
      vld_q <= vld_d;
    end
  end

  assign R         = r_q;
  assign Z         = z_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu32_reg.sv
// Directed-vector bench for alu32_reg; define ALU_XOR_OP_EN to match an XOR-enabled build.
module tb_alu32_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] A, B;
  logic [2:0]  sel;
  logic [31:0] R;
  logic        Z;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  alu32_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A(A), .B(B), .sel(sel),
    .R(R), .Z(Z), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one valid request, then check the captured result just after the edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r);
    @(negedge clk);
    sel = op; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    check({tag, ".R"}, R, exp_r);
    check({tag, ".Z"}, {31'b0, Z}, {31'b0, exp_r == 32'h0});
    check({tag, ".vld"}, {31'b0, out_valid}, 32'h1);
  endtask

  logic [2:0]  s_op [7];
  logic [31:0] s_a  [7];
  logic [31:0] s_b  [7];
  logic [31:0] s_r  [7];
  logic [31:0] xor_exp;
  logic [31:0] held;

  initial begin
    s_op = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000};
    s_a  = '{32'h1, 32'hF0F0, 32'h0F, 32'h3, 32'h100, 32'h1, 32'h5};
    s_b  = '{32'h2, 32'hFF00, 32'hF0, 32'h7, 32'h1,   32'h2, 32'h5};
    s_r  = '{32'h3, 32'hF000, 32'hFF, 32'h15, 32'hFF,  32'h1, 32'h0};
`ifdef ALU_XOR_OP_EN
    xor_exp = 32'h0000_0FF0;
`else
    xor_exp = 32'h0;
`endif

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.R", R, 32'h0);
    check("rst.Z", {31'b0, Z}, 32'h1);
    check("rst.vld", {31'b0, out_valid}, 32'h0);
    @(negedge clk); rst = 1'b0;

    run_op("add", 3'b001, 32'h10, 32'h20, 32'h30);

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    @(negedge clk); in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst.R", R, 32'h0);
    check("arst.Z", {31'b0, Z}, 32'h1);
    check("arst.vld", {31'b0, out_valid}, 32'h0);
    @(negedge clk); rst = 1'b0;

    run_op("add2", 3'b001, 32'h10, 32'h20, 32'h30);
    run_op("and",  3'b010, 32'h1, 32'hF, 32'h1);
    run_op("or",   3'b011, 32'h8, 32'hFF, 32'hFF);
    run_op("mul",  3'b100, 32'h4, 32'h5, 32'h14);
    run_op("sub",  3'b101, 32'h10, 32'h5, 32'hB);
    run_op("subn", 3'b101, 32'h5, 32'h10, 32'hFFFF_FFF5);
    run_op("slt1", 3'b110, 32'h5, 32'h10, 32'h1);
    run_op("slt0", 3'b110, 32'h10, 32'h5, 32'h0);
    run_op("slteq", 3'b110, 32'h1234, 32'h1234, 32'h0);
    run_op("addwrap", 3'b001, 32'hFFFF_FFFF, 32'h1, 32'h0);
    run_op("multrunc", 3'b100, 32'h1_0000, 32'h1_0000, 32'h0);
    run_op("subwrap", 3'b101, 32'h0, 32'h1, 32'hFFFF_FFFF);
    run_op("nop", 3'b000, 32'hAB, 32'hCD, 32'h0);
    run_op("op7", 3'b111, 32'hF, 32'hFFF, xor_exp);
    run_op("slthi", 3'b110, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1);

    // Hold: in_valid low with changing inputs leaves R/Z alone.
    run_op("pre_hold", 3'b011, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A);
    held = 32'hA5A5_5A5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0; sel = 3'(i); A = 32'(i * 7); B = 32'h0;
      @(posedge clk); #1;
      check("hold.R", R, held);
      check("hold.Z", {31'b0, Z}, 32'h0);
      check("hold.vld", {31'b0, out_valid}, 32'h0);
    end

    // Streaming: seven back-to-back requests, one result per cycle.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1; sel = s_op[i]; A = s_a[i]; B = s_b[i];
      @(posedge clk); #1;
      check($sformatf("stream%0d.R", i), R, s_r[i]);
      check($sformatf("stream%0d.Z", i), {31'b0, Z}, {31'b0, s_r[i] == 32'h0});
      check($sformatf("stream%0d.vld", i), {31'b0, out_valid}, 32'h1);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    check("drain.vld", {31'b0, out_valid}, 32'h0);
    check("drain.R", R, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
